// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths, write-back requester indices,
// the hard-wired zero register, and a modulo-increment helper for pointers.
package mips_pkg;

    localparam int MEM_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NREQ_DEF       = 3;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    localparam int REG_ZERO = 0;

    // (i + 1) mod n, for i already in 0..n-1
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found when
// scanning from ptr upward with wrap-around. Shared by write-back and memory port.
module rr_arbiter
    import mips_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        // An out-of-range pointer falls back to scanning from requester 0.
        if (32'(ptr) >= NREQ) begin
            idx = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = PTR_W'(wrap_inc(32'(idx), NREQ));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: one grant per cycle, registered
// write stage. Define REGFILE_WB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NREQ       = NREQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*MEM_WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       wb_hold,
    output logic                       w_ena,
    output logic [ADDR_WIDTH-1:0]      w_addr,
    output logic [MEM_WIDTH-1:0]       w_data,
    output logic                       busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       grant;
    logic [PTR_W-1:0]      scan_start;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [MEM_WIDTH-1:0]  sel_data;

    logic                  w_ena_q, w_ena_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [MEM_WIDTH-1:0]  w_data_q, w_data_d;

`ifdef REGFILE_WB_FIXED_PRIO_EN
    assign scan_start = PTR_W'(REQ_ALU);
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] sel_idx;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_idx = PTR_W'(i);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = PTR_W'(wrap_inc(32'(sel_idx), NREQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= PTR_W'(REQ_ALU);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign scan_start = rr_ptr_q;
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (scan_start),
        .grant (grant)
    );

    // Grant suppressed during reset as well as hold, so no handshake can slip through.
    always_comb begin
        req_ready = grant;
        if (rst || wb_hold) begin
            req_ready = '0;
        end
        xfer     = |req_ready;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // A register-0 transfer still completes; it just never raises the write enable.
    always_comb begin
        w_ena_d  = xfer && (sel_addr != ADDR_WIDTH'(REG_ZERO));
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (xfer) begin
            w_addr_d = sel_addr;
            w_data_d = sel_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ena_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_ena  = w_ena_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign busy   = |(req_valid & ~req_ready);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued at grant time,
// popped by a monitor whenever the write stage presents w_ena.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int W  = AW + DW;

    logic          clk;
    logic          rst;
    logic [2:0]    req_valid;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data;
    logic [2:0]    req_ready;
    logic          wb_hold;
    logic          w_ena;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          busy;

    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    logic [W-1:0]  exp_q[$];
    logic          exp_we_prev;
    int            n_checks;
    int            n_fail;

    regfile_wb_arbiter #(
        .MEM_WIDTH  (DW),
        .ADDR_WIDTH (AW),
        .NREQ       (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_hold   (wb_hold),
        .w_ena     (w_ena),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a[i] = addr;
        d[i] = data;
    endtask

    // One cycle: drive, check grant/busy/write-enable at negedge, queue expected write.
    task automatic step(input logic [2:0] v, input logic hold, input logic [2:0] exp_rdy,
                        input logic exp_busy, input logic push);
        req_valid = v;
        wb_hold   = hold;
        req_addr  = {a[2], a[1], a[0]};
        req_data  = {d[2], d[1], d[0]};
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("w_ena", 32'(w_ena), 32'(exp_we_prev));
        exp_we_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (push && exp_rdy[i] && a[i] != '0) begin
                exp_q.push_back({a[i], d[i]});
                exp_we_prev = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && w_ena) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr %0h data %0h expected no write", w_addr, w_data);
            end else begin
                e = exp_q.pop_front();
                if ({w_addr, w_data} !== e) begin
                    n_fail++;
                    $display("FAIL wb_write: got addr %0h data %0h expected addr %0h data %0h",
                             w_addr, w_data, e[W-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_we_prev = 1'b0;
        rst         = 1'b1;
        wb_hold     = 1'b0;
        set_req(0, 5'd1, 16'h0A01);
        set_req(1, 5'd2, 16'h0A02);
        set_req(2, 5'd3, 16'h0A03);
        req_valid = 3'b111;
        req_addr  = {a[2], a[1], a[0]};
        req_data  = {d[2], d[1], d[0]};

        // reset state
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_w_ena", 32'(w_ena), 32'h0);
        chk("rst_w_addr", 32'(w_addr), 32'h0);
        chk("rst_w_data", 32'(w_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // contention, all three valid
`ifdef REGFILE_WB_FIXED_PRIO_EN
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b110, 1'b0, 3'b010, 1'b1, 1'b1);
`else
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b111, 1'b0, 3'b010, 1'b1, 1'b1);
        step(3'b111, 1'b0, 3'b100, 1'b1, 1'b1);
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
`endif

        // single write from load unit, then idle so w_ena drops
        set_req(1, 5'd7, 16'hBEEF);
        step(3'b010, 1'b0, 3'b010, 1'b0, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

        // register 0 write completes without a write enable
        set_req(0, 5'd0, 16'h1234);
        step(3'b001, 1'b0, 3'b001, 1'b0, 1'b1);
        set_req(1, 5'd8, 16'h0B08);
        set_req(2, 5'd9, 16'h0B09);
`ifdef REGFILE_WB_FIXED_PRIO_EN
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
`else
        step(3'b111, 1'b0, 3'b010, 1'b1, 1'b1);
`endif

        // hold for three cycles, grant on release
        set_req(2, 5'd12, 16'hC0DE);
        step(3'b100, 1'b1, 3'b000, 1'b1, 1'b1);
        step(3'b100, 1'b1, 3'b000, 1'b1, 1'b1);
        step(3'b100, 1'b1, 3'b000, 1'b1, 1'b1);
        step(3'b100, 1'b0, 3'b100, 1'b0, 1'b1);

`ifndef REGFILE_WB_FIXED_PRIO_EN
        // pointer wrap-around (pointer at 0 here)
        set_req(0, 5'd20, 16'h0014);
        set_req(1, 5'd21, 16'h0015);
        set_req(2, 5'd22, 16'h0016);
        step(3'b110, 1'b0, 3'b010, 1'b1, 1'b1);
        step(3'b011, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b101, 1'b0, 3'b100, 1'b1, 1'b1);
`endif

        // same destination from two requesters, serialized in grant order
        set_req(0, 5'd9, 16'h1111);
        set_req(1, 5'd9, 16'h2222);
        step(3'b011, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b010, 1'b0, 3'b010, 1'b0, 1'b1);

        // reset mid-operation drops the pending write
        set_req(0, 5'd4, 16'h4444);
        step(3'b001, 1'b0, 3'b001, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_w_ena", 32'(w_ena), 32'h0);
        chk("midrst_w_addr", 32'(w_addr), 32'h0);
        chk("midrst_w_data", 32'(w_data), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        exp_we_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // after reset the scan restarts at requester 0
        set_req(0, 5'd5, 16'h5555);
        step(3'b111, 1'b0, 3'b001, 1'b1, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 3'b000, 1'b0, 1'b1);

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the MIPS register file's single write port. Accepts write requests from up to NREQ producers (ALU, load unit, mul/div unit) over valid/ready handshakes. Grants one request per cycle by round-robin and drives the register file's write enable, address and data from a registered output stage. Sits between the execution/memory stages and the register file.

## Interface
Parameters:
- MEM_WIDTH, 16, data width; matches the register file word width
- ADDR_WIDTH, 5, register address width (32 registers)
- NREQ, 3, number of requesters; requester 0 = ALU, 1 = load, 2 = mul/div

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*ADDR_WIDTH  packed destination addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NREQ*MEM_WIDTH  packed write data; requester i uses bits [i*MEM_WIDTH +: MEM_WIDTH]
- req_ready  out  NREQ  one-hot (or zero) grant; combinational
- wb_hold  in  1  freeze; no grants while high
- w_ena  out  1  register file write enable (registered)
- w_addr  out  ADDR_WIDTH  register file write address (registered)
- w_data  out  MEM_WIDTH  register file write data (registered)
- busy  out  1  high when any req_valid is pending and not granted this cycle

## Operation
- Transfer for requester i occurs in a cycle where req_valid[i] and req_ready[i] are both high. At most one transfer per cycle.
- Requesters hold req_valid, req_addr and req_data stable until their transfer.
- Round-robin pointer rr_ptr (range 0..NREQ-1):
  - The grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, … with wrap-around modulo NREQ.
  - After a transfer by i, rr_ptr becomes (i+1) mod NREQ.
  - With no transfer, rr_ptr is unchanged.
- wb_hold high: req_ready = 0 and rr_ptr frozen. The output stage loads w_ena = 0.
- Address 0 writes: the transfer still completes (ready asserted, pointer advances), but the output stage loads w_ena = 0. Register 0 is never written.
- Two requesters targeting the same address in the same cycle are serialized in grant order. The later grant wins the final register value.
- busy = |req_valid & ~req_ready.

## Timing
- Grant is combinational in cycle N.
- The output register loads at the end of cycle N. w_ena/w_addr/w_data are valid during cycle N+1, and the register file captures at the end of N+1.
- Write latency from handshake to register file update is 2 clock edges.
- Sustained throughput is one write per cycle.
- A non-transfer cycle loads w_ena = 0. w_addr/w_data hold their previous values.
- Reset (asynchronous, immediate):
  - w_ena = 0, w_addr = 0, w_data = 0, rr_ptr = 0.
  - req_ready = 0 while rst is high.
- Reset asserted mid-operation drops any in-flight output-stage write.

## Configuration
- REGFILE_WB_FIXED_PRIO_EN defined: fixed priority with the lowest index winning (ALU > load > mul/div). rr_ptr logic is removed.
- REGFILE_WB_FIXED_PRIO_EN undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

## Structure
- The shared package `mips_pkg` holds:
  - MEM_WIDTH / ADDR_WIDTH defaults
  - requester index constants REQ_ALU = 0, REQ_LOAD = 1, REQ_MULDIV = 2
  - the REG_ZERO = 0 address constant
- One sub-module, `rr_arbiter` (NREQ-wide request vector and pointer in, one-hot grant out, combinational). It is reused later for the memory port.
- Output register and pointer live in the top module.

## Test plan
- Reset: rst high with all req_valid = 3'b111 → req_ready = 0, w_ena = 0, w_addr = 0, w_data = 0; after release, the first grant goes to requester 0.
- Single write: req_valid = 3'b010, addr = 5'd7, data = 16'hBEEF → req_ready = 3'b010 the same cycle; next cycle w_ena = 1, w_addr = 7, w_data = 16'hBEEF; following cycle w_ena = 0.
- Contention: all three valid continuously with addrs 1, 2, 3 → grants 0, 1, 2, 0 on consecutive cycles; w_addr sequence 1, 2, 3, 1 with w_ena held high.
- Register 0: req_valid = 3'b001, addr = 0, data = 16'h1234 → req_ready[0] = 1; w_ena stays 0; rr_ptr becomes 1.
- Hold: wb_hold high for 3 cycles with req_valid = 3'b100 → req_ready = 0 and busy = 1 throughout; grant on the first cycle after release.
- Fixed priority (macro defined): all valid for 3 cycles → requester 0 granted every cycle; busy = 1.
